fragment_address_sequencer: RTL and testbench
=============================================

# fragment_address_sequencer

Parametrised successor to the single-fragment address register. It accepts a full search key over a valid/ready handshake and splits it into FRAGMENTS equal fragments. For each enabled fragment it issues one SDRAM segment address per handshake, formed as {fragment index, fragment value}. It sits between the key ingress and the SDRAM segment read scheduler, and adds per-key fragment masking, selectable issue order, key-ID tagging and output backpressure.

## Interface
- DATA_BITS, 10: key length in bits.
- FRAGMENTS, 5: number of fragments per key.
- FRAG_BITS, 3: width of the fragment index field. Must satisfy 2^FRAG_BITS >= FRAGMENTS.
- ID_WID, 4: width of the key tag.
- FRAG_WID (localparam) = DATA_BITS/FRAGMENTS. DATA_BITS must be an exact multiple of FRAGMENTS.
- ADDR_WID (localparam) = FRAG_BITS+FRAG_WID.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_key_valid  in  1  key offered.
- o_key_ready  out  1  block can accept a key (registered).
- i_key  in  DATA_BITS  search key; fragment k = i_key[k*FRAG_WID +: FRAG_WID].
- i_key_id  in  ID_WID  tag carried with every address of the key.
- i_frag_mask  in  FRAGMENTS  bit k=1 enables fragment k.
- i_msb_first  in  1  0: issue ascending index; 1: issue descending index.
- o_addr_valid  out  1  address available.
- i_addr_ready  in  1  downstream accepts the address.
- o_sdram_segment_address  out  ADDR_WID  {k[FRAG_BITS-1:0], fragment k}.
- o_frag_index  out  FRAG_BITS  index k of the current address.
- o_key_id  out  ID_WID  tag of the current key.
- o_last  out  1  current address is the final enabled fragment of the key.
- o_busy  out  1  a key is held (state ISSUE).

## Operation
- States: IDLE and ISSUE.
- IDLE: o_key_ready=1, o_addr_valid=0.
  - On i_key_valid & o_key_ready, capture key, id, mask and mode.
  - Mask nonzero: go to ISSUE and load the first enabled fragment. This is the lowest set bit, or the highest set bit when i_msb_first=1.
  - Mask zero: key is consumed and dropped. Stay in IDLE; no address is issued.
- ISSUE: o_key_ready=0, o_addr_valid=1.
  - The address, index, id and last outputs are registered and held stable while o_addr_valid & !i_addr_ready.
  - On handshake with o_last=0: load the next enabled fragment in the captured order, skipping masked fragments.
  - On handshake with o_last=1: go to IDLE. o_addr_valid=0 and o_key_ready=1 on the next cycle.
- o_last = no further set mask bit beyond the current index in the issue direction.
- The captured mask and mode govern the whole key. Input changes during ISSUE are ignored.
- Arithmetic: fragment index is zero-extended/truncated to FRAG_BITS. No carry into the fragment field, and addresses never wrap across fields.

## Timing
- Reset (reset_n=0, asynchronous):
  - State=IDLE; all outputs 0, including o_key_ready.
  - o_key_ready rises on the first clk edge after reset_n deasserts.
- Latency: key accepted at edge T; first address valid after edge T.
- Throughput: N enabled fragments take N handshake cycles plus 1 IDLE cycle per key. Minimum N+1 cycles per key with i_addr_ready held high.
- Zero-mask key: o_key_ready low for exactly one cycle after acceptance.
- Reset mid-ISSUE: the key is abandoned and no further addresses are issued. The next key starts from its own first enabled fragment.
- i_addr_ready has no effect while o_addr_valid=0.

## Test plan
Defaults throughout: DATA_BITS=10, FRAGMENTS=5, FRAG_BITS=3 (FRAG_WID=2, ADDR_WID=5).
- Ascending order: key=0x393, mask=5'b11111, msb_first=0, id=4'h5, ready held 1 -> addresses 0x03, 0x04, 0x09, 0x0E, 0x13 on consecutive cycles. o_last only on 0x13, o_key_id=5 on all; o_key_ready returns 1 one cycle later.
- Descending order: same key with msb_first=1 -> 0x13, 0x0E, 0x09, 0x04, 0x03, with o_last on 0x03.
- Masked fragments: key=0x393, mask=5'b10100 -> 0x09 (index 2) then 0x13 (index 4, o_last=1); nothing else is issued.
- Backpressure: full-mask key, i_addr_ready low for 3 cycles while 0x04 is shown -> 0x04, index 1 and id stay stable. Sequence resumes with 0x09 after ready returns.
- Zero mask: mask=0 accepted -> o_addr_valid never asserts; o_key_ready is 0 for one cycle, then 1.
- Reset mid-operation: reset_n low after the second handshake -> all outputs 0 immediately. After release, a new key with mask=5'b00001 and key=0x001 yields the single address 0x01 with o_last=1.

Source files
------------

// File: rtl/fragment_address_sequencer.sv
// Splits a search key into equal fragments and issues one {index, fragment}
// SDRAM segment address per handshake, in masked ascending or descending order.
module fragment_address_sequencer #(
    parameter int DATA_BITS = 10,
    parameter int FRAGMENTS = 5,
    parameter int FRAG_BITS = 3,
    parameter int ID_WID    = 4
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        i_key_valid,
    output logic                                        o_key_ready,
    input  logic [DATA_BITS-1:0]                        i_key,
    input  logic [ID_WID-1:0]                           i_key_id,
    input  logic [FRAGMENTS-1:0]                        i_frag_mask,
    input  logic                                        i_msb_first,
    output logic                                        o_addr_valid,
    input  logic                                        i_addr_ready,
    output logic [FRAG_BITS+DATA_BITS/FRAGMENTS-1:0]    o_sdram_segment_address,
    output logic [FRAG_BITS-1:0]                        o_frag_index,
    output logic [ID_WID-1:0]                           o_key_id,
    output logic                                        o_last,
    output logic                                        o_busy
);

    localparam int FRAG_WID = DATA_BITS / FRAGMENTS;
    localparam int ADDR_WID = FRAG_BITS + FRAG_WID;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   key_q, key_d;
    logic [FRAGMENTS-1:0]   mask_q, mask_d;
    logic                   msb_q, msb_d;
    logic                   key_ready_q, key_ready_d;
    logic                   addr_valid_q, addr_valid_d;
    logic [ADDR_WID-1:0]    addr_q, addr_d;
    logic [FRAG_BITS-1:0]   index_q, index_d;
    logic [ID_WID-1:0]      id_q, id_d;
    logic                   last_q, last_d;

    logic [FRAG_BITS-1:0]   first_idx_s;
    logic                   first_last_s;
    logic [FRAG_BITS-1:0]   next_idx_s;
    logic                   next_last_s;

    // Enabled fragments strictly beyond cur in the issue direction.
    function automatic logic [FRAGMENTS-1:0] beyond(
        input logic [FRAGMENTS-1:0] m,
        input logic [FRAG_BITS-1:0] cur,
        input logic                 msb
    );
        logic [FRAGMENTS-1:0] r;
        r = '0;
        for (int k = 0; k < FRAGMENTS; k++) begin
            if (msb) begin
                r[k] = m[k] && (k < int'(cur));
            end else begin
                r[k] = m[k] && (k > int'(cur));
            end
        end
        return r;
    endfunction

    // Nearest set bit in the issue direction: lowest when ascending, highest when descending.
    function automatic logic [FRAG_BITS-1:0] pick_bit(
        input logic [FRAGMENTS-1:0] m,
        input logic                 msb
    );
        logic [FRAG_BITS-1:0] r;
        r = '0;
        if (msb) begin
            for (int k = 0; k < FRAGMENTS; k++) begin
                if (m[k]) begin
                    r = k[FRAG_BITS-1:0];
                end
            end
        end else begin
            for (int k = FRAGMENTS - 1; k >= 0; k--) begin
                if (m[k]) begin
                    r = k[FRAG_BITS-1:0];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [FRAG_WID-1:0] frag_of(
        input logic [DATA_BITS-1:0] key,
        input logic [FRAG_BITS-1:0] k
    );
        logic [DATA_BITS-1:0] sh;
        sh = key >> (int'(k) * FRAG_WID);
        return sh[FRAG_WID-1:0];
    endfunction

    // Candidate fragment for a fresh key and for the step after the current one.
    always_comb begin
        first_idx_s  = pick_bit(i_frag_mask, i_msb_first);
        first_last_s = (beyond(i_frag_mask, first_idx_s, i_msb_first) == '0);
        next_idx_s   = pick_bit(beyond(mask_q, index_q, msb_q), msb_q);
        next_last_s  = (beyond(mask_q, next_idx_s, msb_q) == '0);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        mask_d       = mask_q;
        msb_d        = msb_q;
        key_ready_d  = key_ready_q;
        addr_valid_d = addr_valid_q;
        addr_d       = addr_q;
        index_d      = index_q;
        id_d         = id_q;
        last_d       = last_q;
        case (state_q)
            IDLE: begin
                key_ready_d  = 1'b1;
                addr_valid_d = 1'b0;
                if (i_key_valid && key_ready_q) begin
                    key_d  = i_key;
                    mask_d = i_frag_mask;
                    msb_d  = i_msb_first;
                    // A zero-mask key is swallowed; ready still dips for one cycle.
                    key_ready_d = 1'b0;
                    if (i_frag_mask != '0) begin
                        state_d      = ISSUE;
                        addr_valid_d = 1'b1;
                        addr_d       = {first_idx_s, frag_of(i_key, first_idx_s)};
                        index_d      = first_idx_s;
                        id_d         = i_key_id;
                        last_d       = first_last_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                key_ready_d  = 1'b0;
                addr_valid_d = 1'b1;
                if (i_addr_ready) begin
                    if (last_q) begin
                        state_d      = IDLE;
                        addr_valid_d = 1'b0;
                        key_ready_d  = 1'b1;
                    end else begin
                        addr_d  = {next_idx_s, frag_of(key_q, next_idx_s)};
                        index_d = next_idx_s;
                        last_d  = next_last_s;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d      = IDLE;
                key_ready_d  = 1'b0;
                addr_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            key_q        <= '0;
            mask_q       <= '0;
            msb_q        <= 1'b0;
            key_ready_q  <= 1'b0;
            addr_valid_q <= 1'b0;
            addr_q       <= '0;
            index_q      <= '0;
            id_q         <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            mask_q       <= mask_d;
            msb_q        <= msb_d;
            key_ready_q  <= key_ready_d;
            addr_valid_q <= addr_valid_d;
            addr_q       <= addr_d;
            index_q      <= index_d;
            id_q         <= id_d;
            last_q       <= last_d;
        end
    end

    assign o_key_ready             = key_ready_q;
    assign o_addr_valid            = addr_valid_q;
    assign o_sdram_segment_address = addr_q;
    assign o_frag_index            = index_q;
    assign o_key_id                = id_q;
    assign o_last                  = last_q;
    assign o_busy                  = (state_q == ISSUE);

endmodule

// File: tb/tb_fragment_address_sequencer.sv
// Randomised and directed bench for fragment_address_sequencer against a
// queue-based model of the fragment issue order.
module tb_fragment_address_sequencer;

    localparam int DB = 10;
    localparam int FR = 5;
    localparam int FB = 3;
    localparam int IW = 4;
    localparam int FW = 2;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_key_valid;
    logic          o_key_ready;
    logic [DB-1:0] i_key;
    logic [IW-1:0] i_key_id;
    logic [FR-1:0] i_frag_mask;
    logic          i_msb_first;
    logic          o_addr_valid;
    logic          i_addr_ready;
    logic [AW-1:0] o_sdram_segment_address;
    logic [FB-1:0] o_frag_index;
    logic [IW-1:0] o_key_id;
    logic          o_last;
    logic          o_busy;

    typedef struct {
        int addr;
        int idx;
        bit last;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] obs_addr[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    fragment_address_sequencer #(
        .DATA_BITS(DB), .FRAGMENTS(FR), .FRAG_BITS(FB), .ID_WID(IW)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .i_key_valid             (i_key_valid),
        .o_key_ready             (o_key_ready),
        .i_key                   (i_key),
        .i_key_id                (i_key_id),
        .i_frag_mask             (i_frag_mask),
        .i_msb_first             (i_msb_first),
        .o_addr_valid            (o_addr_valid),
        .i_addr_ready            (i_addr_ready),
        .o_sdram_segment_address (o_sdram_segment_address),
        .o_frag_index            (o_frag_index),
        .o_key_id                (o_key_id),
        .o_last                  (o_last),
        .o_busy                  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_key_ready"}, 32'(o_key_ready), 32'd0);
        check_eq({tag, "_addr_valid"}, 32'(o_addr_valid), 32'd0);
        check_eq({tag, "_addr"}, 32'(o_sdram_segment_address), 32'd0);
        check_eq({tag, "_index"}, 32'(o_frag_index), 32'd0);
        check_eq({tag, "_key_id"}, 32'(o_key_id), 32'd0);
        check_eq({tag, "_last"}, 32'(o_last), 32'd0);
        check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    // Model: visit fragments in the chosen order, keep enabled ones,
    // address = index * 2^FW + fragment value, last = final entry.
    task automatic build_model(input logic [DB-1:0] key, input logic [FR-1:0] mask, input bit msb);
        int   order[$];
        int   kv;
        exp_t e;
        exp_q.delete();
        kv = int'(key);
        for (int j = 0; j < FR; j++) begin
            int k;
            k = msb ? (FR - 1 - j) : j;
            if (mask[k]) order.push_back(k);
        end
        foreach (order[p]) begin
            e.idx  = order[p];
            e.addr = order[p] * (1 << FW) + ((kv >> (order[p] * FW)) % (1 << FW));
            e.last = (p == order.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_key(input logic [DB-1:0] key, input logic [IW-1:0] id, input logic [FR-1:0] mask,
                           input bit msb, input int stall_pos, input int stall_cnt, input bit rnd);
        int stalls;
        check_eq("ready_before_key", 32'(o_key_ready), 32'd1);
        build_model(key, mask, msb);
        obs_addr.delete();
        i_key_valid  = 1'b1;
        i_key        = key;
        i_key_id     = id;
        i_frag_mask  = mask;
        i_msb_first  = msb;
        i_addr_ready = 1'($urandom);
        step();
        i_key_valid = 1'b0;
        if (mask == '0) begin
            check_eq("zero_mask_valid", 32'(o_addr_valid), 32'd0);
            check_eq("zero_mask_ready_low", 32'(o_key_ready), 32'd0);
            check_eq("zero_mask_busy", 32'(o_busy), 32'd0);
            step();
            check_eq("zero_mask_valid2", 32'(o_addr_valid), 32'd0);
            check_eq("zero_mask_ready_back", 32'(o_key_ready), 32'd1);
        end else begin
            foreach (exp_q[p]) begin
                stalls = (p == stall_pos) ? stall_cnt : (rnd ? int'($urandom_range(0, 2)) : 0);
                for (int s = 0; s <= stalls; s++) begin
                    check_eq("addr_valid", 32'(o_addr_valid), 32'd1);
                    check_eq("key_ready_low", 32'(o_key_ready), 32'd0);
                    check_eq("busy", 32'(o_busy), 32'd1);
                    check_eq("addr", 32'(o_sdram_segment_address), exp_q[p].addr);
                    check_eq("index", 32'(o_frag_index), exp_q[p].idx);
                    check_eq("key_id", 32'(o_key_id), 32'(id));
                    check_eq("last", 32'(o_last), 32'(exp_q[p].last));
                    if (s == stalls) obs_addr.push_back(o_sdram_segment_address);
                    i_addr_ready = (s == stalls);
                    if (rnd) begin
                        i_key_valid = 1'($urandom);
                        i_key       = DB'($urandom);
                        i_key_id    = IW'($urandom);
                        i_frag_mask = FR'($urandom);
                        i_msb_first = 1'($urandom);
                    end
                    step();
                end
            end
            i_key_valid  = 1'b0;
            i_addr_ready = 1'($urandom);
            check_eq("valid_after_last", 32'(o_addr_valid), 32'd0);
            check_eq("ready_after_last", 32'(o_key_ready), 32'd1);
            check_eq("busy_after_last", 32'(o_busy), 32'd0);
        end
    endtask

    initial begin
        logic [AW-1:0] asc[5];
        logic [AW-1:0] desc[5];
        logic [FR-1:0] m;
        asc  = '{5'h03, 5'h04, 5'h09, 5'h0E, 5'h13};
        desc = '{5'h13, 5'h0E, 5'h09, 5'h04, 5'h03};

        reset_n      = 1'b0;
        i_key_valid  = 1'b0;
        i_key        = '0;
        i_key_id     = '0;
        i_frag_mask  = '0;
        i_msb_first  = 1'b0;
        i_addr_ready = 1'b0;
        #3;
        check_all_zero("reset");
        step();
        step();
        check_eq("ready_held_in_reset", 32'(o_key_ready), 32'd0);
        reset_n = 1'b1;
        step();
        check_eq("ready_after_reset", 32'(o_key_ready), 32'd1);

        run_key(10'h393, 4'h5, 5'b11111, 1'b0, -1, 0, 1'b0);
        check_eq("asc_count", 32'(obs_addr.size()), 32'd5);
        for (int i = 0; i < 5; i++) check_eq("asc_seq", 32'(obs_addr[i]), 32'(asc[i]));

        run_key(10'h393, 4'h5, 5'b11111, 1'b1, -1, 0, 1'b0);
        check_eq("desc_count", 32'(obs_addr.size()), 32'd5);
        for (int i = 0; i < 5; i++) check_eq("desc_seq", 32'(obs_addr[i]), 32'(desc[i]));

        run_key(10'h393, 4'hA, 5'b10100, 1'b0, -1, 0, 1'b0);
        check_eq("masked_count", 32'(obs_addr.size()), 32'd2);
        check_eq("masked_first", 32'(obs_addr[0]), 32'h09);
        check_eq("masked_second", 32'(obs_addr[1]), 32'h13);

        run_key(10'h393, 4'h7, 5'b11111, 1'b0, 1, 3, 1'b0);
        for (int i = 0; i < 5; i++) check_eq("backpressure_seq", 32'(obs_addr[i]), 32'(asc[i]));

        run_key(10'h2B6, 4'h1, 5'b00000, 1'b0, -1, 0, 1'b0);

        // Reset in the middle of a key.
        check_eq("rst_mid_ready", 32'(o_key_ready), 32'd1);
        i_key_valid  = 1'b1;
        i_key        = 10'h393;
        i_key_id     = 4'h9;
        i_frag_mask  = 5'b11111;
        i_msb_first  = 1'b0;
        i_addr_ready = 1'b1;
        step();
        i_key_valid = 1'b0;
        check_eq("rst_mid_addr0", 32'(o_sdram_segment_address), 32'h03);
        step();
        check_eq("rst_mid_addr1", 32'(o_sdram_segment_address), 32'h04);
        step();
        check_eq("rst_mid_addr2", 32'(o_sdram_segment_address), 32'h09);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid_async");
        step();
        step();
        check_all_zero("rst_mid_held");
        reset_n      = 1'b1;
        i_addr_ready = 1'b0;
        step();
        check_eq("rst_mid_ready_back", 32'(o_key_ready), 32'd1);
        check_eq("rst_mid_no_valid", 32'(o_addr_valid), 32'd0);
        run_key(10'h001, 4'h3, 5'b00001, 1'b0, -1, 0, 1'b0);
        check_eq("post_rst_count", 32'(obs_addr.size()), 32'd1);
        check_eq("post_rst_addr", 32'(obs_addr[0]), 32'h01);

        // Randomised keys with stalls, idle gaps and input noise during issue.
        for (int n = 0; n < 60; n++) begin
            m = ($urandom_range(0, 7) == 0) ? 5'b00000 : FR'($urandom);
            run_key(DB'($urandom), IW'($urandom), m, 1'($urandom), -1, 0, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                i_addr_ready = 1'($urandom);
                step();
                check_eq("gap_valid", 32'(o_addr_valid), 32'd0);
                check_eq("gap_ready", 32'(o_key_ready), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
